// File: rtl/vertical_scale_pkg.sv
// Shared types and constants for the per-channel vertical scale controller.
package vertical_scale_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_UP   = 2'd2,
        CMD_DOWN = 2'd3
    } cmd_e;

    localparam int DEFAULT_MIN_EXP   = 0;
    localparam int DEFAULT_MAX_EXP   = 10;
    localparam int DEFAULT_RESET_EXP = 3;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A single-channel build still needs a one-bit select port.
    function automatic int sel_width(input int num_channels);
        return (num_channels > 1) ? clog2(num_channels) : 1;
    endfunction

    localparam int DEFAULT_SEL_BITS = sel_width(2);

endpackage

// File: rtl/power_of_two_log2.sv
// Combinational encoder: bit index of a one-hot factor plus validity flags.
module power_of_two_log2 #(
    parameter int FACTOR_BITS = 11,
    parameter int EXP_BITS    = 4,
    parameter int MIN_EXP     = 0,
    parameter int MAX_EXP     = 10
) (
    input  logic [FACTOR_BITS-1:0] factor,
    output logic [EXP_BITS-1:0]    exponent,
    output logic                   is_pow2,
    output logic                   in_range
);

    int index;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        index = 0;
        for (int i = 0; i < FACTOR_BITS; i++) begin
            if (factor[i]) begin
                index = i;
            end
        end
        is_pow2  = (factor != '0) && ((factor & (factor - FACTOR_BITS'(1))) == '0);
        in_range = (index >= MIN_EXP) && (index <= MAX_EXP);
        exponent = EXP_BITS'(index);
    end

endmodule

// File: rtl/vertical_scale_exponent_ctrl.sv
// Per-channel vertical scale state: two-stage command pipeline driving registered exponent/factor outputs.
module vertical_scale_exponent_ctrl
    import vertical_scale_pkg::*;
#(
    parameter int NUM_CHANNELS        = 2,
    parameter int SCALE_FACTOR_SIZE   = 11,
    parameter int SCALE_EXPONENT_BITS = 4,
    parameter int MIN_EXP             = DEFAULT_MIN_EXP,
    parameter int MAX_EXP             = DEFAULT_MAX_EXP,
    parameter int RESET_EXP           = DEFAULT_RESET_EXP
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [sel_width(NUM_CHANNELS)-1:0]           channelSelect,
    input  logic                                         loadValid,
    input  logic [SCALE_FACTOR_SIZE-1:0]                 loadFactor,
    input  logic                                         stepUp,
    input  logic                                         stepDown,
    output logic [NUM_CHANNELS*SCALE_EXPONENT_BITS-1:0]  scaleExponents,
    output logic [NUM_CHANNELS*SCALE_FACTOR_SIZE-1:0]    scaleFactors,
    output logic [NUM_CHANNELS-1:0]                      exponentChanged,
    output logic [NUM_CHANNELS-1:0]                      atMax,
    output logic [NUM_CHANNELS-1:0]                      atMin,
    output logic                                         loadError
);

    localparam int CSW = sel_width(NUM_CHANNELS);
    localparam int EB  = SCALE_EXPONENT_BITS;
    localparam int FW  = SCALE_FACTOR_SIZE;

    typedef struct packed {
        cmd_e           cmd;
        logic [CSW-1:0] ch;
        logic [EB-1:0]  exp;
        logic           is_pow2;
        logic           in_range;
        logic           ch_valid;
    } stage1_t;

    stage1_t       s1_d, s1_q;
    logic [EB-1:0] enc_exp;
    logic          enc_pow2, enc_in_range;

    power_of_two_log2 #(
        .FACTOR_BITS (FW),
        .EXP_BITS    (EB),
        .MIN_EXP     (MIN_EXP),
        .MAX_EXP     (MAX_EXP)
    ) u_encoder (
        .factor   (loadFactor),
        .exponent (enc_exp),
        .is_pow2  (enc_pow2),
        .in_range (enc_in_range)
    );

    // Load wins over steps; opposing steps cancel.
    always_comb begin
        s1_d          = '0;
        s1_d.cmd      = CMD_NONE;
        if (loadValid) begin
            s1_d.cmd = CMD_LOAD;
        end else if (stepUp && !stepDown) begin
            s1_d.cmd = CMD_UP;
        end else if (stepDown && !stepUp) begin
            s1_d.cmd = CMD_DOWN;
        end
        s1_d.ch       = channelSelect;
        s1_d.exp      = enc_exp;
        s1_d.is_pow2  = enc_pow2;
        s1_d.in_range = enc_in_range;
        s1_d.ch_valid = int'(channelSelect) < NUM_CHANNELS;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
        end else begin
            // NOTE: clocked state is always written with non-blocking assignments.
            s1_q <= s1_d;
        end
    end

    logic [EB-1:0]           exp_q    [NUM_CHANNELS];
    logic [EB-1:0]           exp_d    [NUM_CHANNELS];
    logic [FW-1:0]           factor_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] changed_q, at_max_q, at_min_q;
    logic                    load_ok, load_error_d, load_error_q;

    assign load_ok = s1_q.ch_valid && s1_q.is_pow2 && s1_q.in_range;

    // Steps are evaluated against the live register so consecutive steps accumulate.
    always_comb begin
        load_error_d = (s1_q.cmd == CMD_LOAD) && !load_ok;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            exp_d[k] = exp_q[k];
            if (s1_q.ch_valid && (int'(s1_q.ch) == k)) begin
                case (s1_q.cmd)
                    CMD_LOAD: if (load_ok)                   exp_d[k] = s1_q.exp;
                    CMD_UP:   if (exp_q[k] != EB'(MAX_EXP))  exp_d[k] = exp_q[k] + EB'(1);
                    CMD_DOWN: if (exp_q[k] != EB'(MIN_EXP))  exp_d[k] = exp_q[k] - EB'(1);
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: this per-channel array is architectural state rather than a RAM, so every entry is reset.
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                exp_q[k]    <= EB'(RESET_EXP);
                factor_q[k] <= FW'(1) << RESET_EXP;
            end
            changed_q    <= '0;
            at_max_q     <= {NUM_CHANNELS{RESET_EXP == MAX_EXP}};
            at_min_q     <= {NUM_CHANNELS{RESET_EXP == MIN_EXP}};
            load_error_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                exp_q[k]     <= exp_d[k];
                factor_q[k]  <= FW'(1) << exp_d[k];
                changed_q[k] <= exp_d[k] != exp_q[k];
                at_max_q[k]  <= exp_d[k] == EB'(MAX_EXP);
                at_min_q[k]  <= exp_d[k] == EB'(MIN_EXP);
            end
            load_error_q <= load_error_d;
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_pack
        assign scaleExponents[k*EB +: EB] = exp_q[k];
        assign scaleFactors[k*FW +: FW]   = factor_q[k];
    end

    assign exponentChanged = changed_q;
    assign atMax           = at_max_q;
    assign atMin           = at_min_q;
    assign loadError       = load_error_q;

endmodule

// File: tb/tb_vertical_scale_exponent_ctrl.sv
// Directed plus randomized bench for vertical_scale_exponent_ctrl against a command-level reference model.
module tb_vertical_scale_exponent_ctrl;

    localparam int NCH  = 3;
    localparam int FW   = 11;
    localparam int EB   = 4;
    localparam int MINE = 0;
    localparam int MAXE = 10;
    localparam int RSTE = 3;
    localparam int CSW  = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic [CSW-1:0]     channelSelect;
    logic               loadValid;
    logic [FW-1:0]      loadFactor;
    logic               stepUp;
    logic               stepDown;
    logic [NCH*EB-1:0]  scaleExponents;
    logic [NCH*FW-1:0]  scaleFactors;
    logic [NCH-1:0]     exponentChanged;
    logic [NCH-1:0]     atMax;
    logic [NCH-1:0]     atMin;
    logic               loadError;

    vertical_scale_exponent_ctrl #(
        .NUM_CHANNELS        (NCH),
        .SCALE_FACTOR_SIZE   (FW),
        .SCALE_EXPONENT_BITS (EB),
        .MIN_EXP             (MINE),
        .MAX_EXP             (MAXE),
        .RESET_EXP           (RSTE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .channelSelect   (channelSelect),
        .loadValid       (loadValid),
        .loadFactor      (loadFactor),
        .stepUp          (stepUp),
        .stepDown        (stepDown),
        .scaleExponents  (scaleExponents),
        .scaleFactors    (scaleFactors),
        .exponentChanged (exponentChanged),
        .atMax           (atMax),
        .atMin           (atMin),
        .loadError       (loadError)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: exponent per channel plus the command waiting to take effect.
    int             m_exp [NCH];
    logic [NCH-1:0] m_changed;
    logic           m_err;
    logic           p_valid, p_lv, p_up, p_dn;
    logic [FW-1:0]  p_lf;
    logic [CSW-1:0] p_ch;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) m_exp[k] = RSTE;
        m_changed = '0;
        m_err     = 1'b0;
        p_valid   = 1'b0;
    endfunction

    function automatic void model_apply();
        int ch, old_exp, idx;
        m_changed = '0;
        m_err     = 1'b0;
        if (!p_valid) return;
        ch = int'(p_ch);
        if (ch >= NCH) begin
            m_err = p_lv;
            return;
        end
        old_exp = m_exp[ch];
        if (p_lv) begin
            if ($countones(p_lf) == 1) begin
                idx = $clog2(p_lf);
                if (idx >= MINE && idx <= MAXE) m_exp[ch] = idx;
                else m_err = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (p_up && !p_dn) begin
            m_exp[ch] = (old_exp < MAXE) ? old_exp + 1 : old_exp;
        end else if (p_dn && !p_up) begin
            m_exp[ch] = (old_exp > MINE) ? old_exp - 1 : old_exp;
        end
        m_changed[ch] = (m_exp[ch] != old_exp);
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("exponent[%0d]", k), 32'(scaleExponents[k*EB +: EB]), m_exp[k]);
            check($sformatf("factor[%0d]", k),   32'(scaleFactors[k*FW +: FW]),   32'(1) << m_exp[k]);
            check($sformatf("atMax[%0d]", k),    32'(atMax[k]), 32'(m_exp[k] == MAXE));
            check($sformatf("atMin[%0d]", k),    32'(atMin[k]), 32'(m_exp[k] == MINE));
        end
        check("exponentChanged", 32'(exponentChanged), 32'(m_changed));
        check("loadError",       32'(loadError),       32'(m_err));
    endtask

    // Drive one command, cross one edge, then compare against the model.
    task automatic cycle(input logic lv, input logic [FW-1:0] lf, input logic up,
                         input logic dn, input logic [CSW-1:0] ch);
        loadValid     = lv;
        loadFactor    = lf;
        stepUp        = up;
        stepDown      = dn;
        channelSelect = ch;
        @(posedge clock);
        #1;
        model_apply();
        p_valid = 1'b1;
        p_lv    = lv;
        p_lf    = lf;
        p_up    = up;
        p_dn    = dn;
        p_ch    = ch;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic reset_mid_run();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        loadValid     = 1'b0;
        loadFactor    = '0;
        stepUp        = 1'b0;
        stepDown      = 1'b0;
        channelSelect = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;

        // Absolute load on channel 1.
        cycle(1'b1, 11'd64, 1'b0, 1'b0, 2'd1);
        idle(3);

        // Rejected loads: two bits set, and zero.
        cycle(1'b1, 11'd48, 1'b0, 1'b0, 2'd0);
        idle(2);
        cycle(1'b1, 11'd0, 1'b0, 1'b0, 2'd0);
        idle(2);

        // Reloading the current value is accepted silently.
        cycle(1'b1, 11'd8, 1'b0, 1'b0, 2'd2);
        idle(2);

        // Back-to-back steps accumulate.
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 2'd0);
        idle(2);

        // Saturate at the top, then cancelled step pair.
        cycle(1'b1, 11'd1024, 1'b0, 1'b0, 2'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 2'd0);
        idle(2);
        cycle(1'b0, '0, 1'b1, 1'b1, 2'd0);
        idle(2);

        // Saturate at the bottom.
        cycle(1'b1, 11'd1, 1'b0, 1'b0, 2'd2);
        cycle(1'b0, '0, 1'b0, 1'b1, 2'd2);
        idle(2);

        // Out-of-range channel: load errors, step is silently ignored.
        cycle(1'b1, 11'd16, 1'b0, 1'b0, 2'd3);
        idle(2);
        cycle(1'b0, '0, 1'b0, 1'b1, 2'd3);
        idle(2);

        // In-flight command dropped by reset.
        cycle(1'b0, '0, 1'b1, 1'b0, 2'd0);
        reset_mid_run();
        idle(3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic          lv, up, dn;
            logic [FW-1:0] lf;
            logic [CSW-1:0] ch;
            if ($urandom_range(0, 59) == 0) begin
                reset_mid_run();
            end else begin
                lv = ($urandom_range(0, 3) == 0);
                lf = ($urandom_range(0, 9) < 7) ? FW'(1) << $urandom_range(0, FW - 1)
                                                : FW'($urandom);
                up = $urandom_range(0, 1) == 1;
                dn = $urandom_range(0, 2) == 0;
                ch = CSW'($urandom_range(0, 3));
                cycle(lv, lf, up, dn, ch);
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
